// File: rtl/snoop_bus_ctrl_pkg.sv
// snoop_bus_ctrl_pkg: sizing and shared types for the MESI snoop bus
package snoop_bus_ctrl_pkg;
  localparam int NUM_CPUS = 4;
  localparam int XLEN = 32;
  localparam int LINE_W = 128;
  localparam int SNP_TIMEOUT = 15;
  localparam int SRC_W = $clog2(NUM_CPUS);
  typedef enum logic [1:0] {BUS_RD, BUS_RDX, BUS_UPGR} bus_tx_t;
  typedef struct packed {
    logic valid;
    logic [SRC_W-1:0] source;
    logic [XLEN-1:0] addr;
    bus_tx_t bus_tx;
  } bus_msg_t;
  typedef enum logic [2:0] {IDLE, BCAST, COLLECT, MEM_RD, MEM_WB, DONE} snoop_state_t;
endpackage

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] idx;
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) gnt = N'(1) << idx;
    end
  end
endmodule

// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: single-transaction MESI snoop bus with arbitration, response merge and memory fallback
module snoop_bus_ctrl
  import snoop_bus_ctrl_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CPUS-1:0]              req,
  input  logic [NUM_CPUS-1:0][XLEN-1:0]    req_addr,
  input  bus_tx_t [NUM_CPUS-1:0]           req_tx,
  output logic [NUM_CPUS-1:0]              gnt,
  output bus_msg_t                         bus_msg,
  input  logic [NUM_CPUS-1:0]              snp_ack,
  input  logic [NUM_CPUS-1:0]              snp_shared,
  input  logic [NUM_CPUS-1:0]              snp_dirty,
  input  logic [NUM_CPUS-1:0][LINE_W-1:0]  snp_data,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [XLEN-1:0]                  mem_addr,
  output logic [LINE_W-1:0]                mem_wdata,
  input  logic                             mem_ack,
  input  logic [LINE_W-1:0]                mem_rdata,
  output logic [NUM_CPUS-1:0]              done,
  output logic                             resp_shared,
  output logic [LINE_W-1:0]                resp_data,
  output logic                             resp_err
);
  localparam int CW = $clog2(SNP_TIMEOUT + 1);
  snoop_state_t state, nxt;
  logic [SRC_W-1:0] rr, src, win, lo, dty_idx;
  logic [XLEN-1:0] addr_r;
  bus_tx_t tx_r;
  logic [NUM_CPUS-1:0] arb_gnt, src_oh, ack_r, ack_n, v, d;
  logic shr_r, dty_r, err_r, shr_n, dty_n, err_n, take, all_acked, tmo;
  logic [CW-1:0] cnt;
  logic [LINE_W-1:0] line_r;

  rr_arbiter #(.N(NUM_CPUS)) u_arb (.req(req), .ptr(rr), .gnt(arb_gnt));

  assign mem_addr = addr_r;
  assign mem_wdata = line_r;

  // v holds only first-time acks from peers, so a repeated ack cannot count a dirty owner twice
  always_comb begin
    src_oh = NUM_CPUS'(1) << src;
    v = state == COLLECT ? snp_ack & ~src_oh & ~ack_r : '0;
    d = v & snp_dirty;
    lo = '0;
    win = '0;
    for (int i = NUM_CPUS - 1; i >= 0; i--) begin
      if (d[i]) lo = SRC_W'(i);
      if (arb_gnt[i]) win = SRC_W'(i);
    end
    ack_n = ack_r | v;
    all_acked = &(ack_n | src_oh);
    tmo = state == COLLECT && !all_acked && cnt == CW'(SNP_TIMEOUT - 1);
    shr_n = shr_r | |(v & (snp_shared | snp_dirty));
    dty_n = dty_r | |d;
    take = |d && (!dty_r || lo < dty_idx);
    err_n = err_r | tmo | (dty_r && |d) | |(d & (d - NUM_CPUS'(1)));
  end

  always_comb begin
    nxt = state;
    gnt = '0;
    bus_msg = '0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    done = '0;
    case (state)
      IDLE: begin
        gnt = arb_gnt;
        if (|req) nxt = BCAST;
      end
      BCAST: begin
        bus_msg = '{1'b1, src, addr_r, tx_r};
        nxt = COLLECT;
      end
      COLLECT: if (all_acked || tmo) nxt = tx_r == BUS_UPGR ? DONE : dty_n ? MEM_WB : MEM_RD;
      MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ack) nxt = DONE;
      end
      MEM_WB: begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        if (mem_ack) nxt = DONE;
      end
      DONE: begin
        done = src_oh;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr <= '0;
      src <= '0;
      addr_r <= '0;
      tx_r <= BUS_RD;
      ack_r <= '0;
      shr_r <= 1'b0;
      dty_r <= 1'b0;
      err_r <= 1'b0;
      dty_idx <= '0;
      cnt <= '0;
      line_r <= '0;
      resp_shared <= 1'b0;
      resp_data <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && |req) begin
        src <= win;
        addr_r <= req_addr[win];
        tx_r <= req_tx[win];
      end
      if (state == BCAST) begin
        ack_r <= '0;
        shr_r <= 1'b0;
        dty_r <= 1'b0;
        err_r <= 1'b0;
        cnt <= '0;
      end
      if (state == COLLECT) begin
        ack_r <= ack_n;
        shr_r <= shr_n;
        dty_r <= dty_n;
        err_r <= err_n;
        if (cnt != CW'(SNP_TIMEOUT)) cnt <= cnt + CW'(1);
        if (take) begin
          dty_idx <= lo;
          line_r <= snp_data[lo];
        end
      end
      if (nxt == DONE && state != DONE) begin
        resp_shared <= shr_n;
        resp_err <= err_n;
        resp_data <= state == MEM_RD ? mem_rdata : state == MEM_WB ? line_r : '0;
      end
      if (state == DONE) rr <= src == SRC_W'(NUM_CPUS - 1) ? '0 : src + SRC_W'(1);
    end
  end

  assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  assert property (@(posedge clk) disable iff (rst) $onehot0(done));
  assert property (@(posedge clk) disable iff (rst) bus_msg.valid |=> !bus_msg.valid);
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb_snoop_bus_ctrl: vector table driven through a scoreboard, plus reset and fairness sequences
module tb_snoop_bus_ctrl;
  import snoop_bus_ctrl_pkg::*;

  typedef struct {
    int src;
    bus_tx_t tx;
    logic [XLEN-1:0] addr;
    logic [NUM_CPUS-1:0] ack, shr, dty;
    logic [LINE_W-1:0] rdata;
    int mem;
    logic esh;
    logic [LINE_W-1:0] edata;
    logic eerr;
    int elat;
  } vec_t;

  typedef struct {
    logic [NUM_CPUS-1:0] done;
    logic esh;
    logic [LINE_W-1:0] edata;
    logic eerr;
    int elat;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [NUM_CPUS-1:0] req = '0, snp_ack = '0, snp_shared = '0, snp_dirty = '0, gnt, done;
  logic [NUM_CPUS-1:0][XLEN-1:0] req_addr = '0;
  bus_tx_t [NUM_CPUS-1:0] req_tx;
  logic [NUM_CPUS-1:0][LINE_W-1:0] snp_data;
  bus_msg_t bus_msg;
  logic mem_req, mem_we, mem_ack = 1'b0, resp_shared, resp_err;
  logic [XLEN-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata, mem_rdata = '0, resp_data;
  int checks = 0, passed = 0;
  vec_t tbl[6];
  vec_t rv[2];
  vec_t fv;
  exp_t sb[$];

  always #5 clk = ~clk;

  snoop_bus_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_tx(req_tx), .gnt(gnt),
    .bus_msg(bus_msg), .snp_ack(snp_ack), .snp_shared(snp_shared), .snp_dirty(snp_dirty),
    .snp_data(snp_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .done(done),
    .resp_shared(resp_shared), .resp_data(resp_data), .resp_err(resp_err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ctl", {gnt, bus_msg, mem_req, mem_we, done, resp_shared, resp_err}, '0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_resp_data", resp_data, '0);
  endtask

  // called at a negedge while the DUT is idle; returns at the negedge after the done pulse
  task automatic do_tx(input vec_t v, input bit hold);
    int n, lat, mem_op;
    logic [XLEN-1:0] maddr;
    logic [LINE_W-1:0] mwd;
    bus_msg_t em;
    exp_t e;
    req_addr[v.src] = v.addr;
    req_tx[v.src] = v.tx;
    req[v.src] = 1'b1;
    #1;
    n = 0;
    while (gnt == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("gnt", gnt, 4'b1 << v.src);
    e.done = 4'b1 << v.src;
    e.esh = v.esh;
    e.edata = v.edata;
    e.eerr = v.eerr;
    e.elat = v.elat;
    sb.push_back(e);
    @(negedge clk);
    em.valid = 1'b1;
    em.source = SRC_W'(v.src);
    em.addr = v.addr;
    em.bus_tx = v.tx;
    chk("bus_msg", bus_msg, em);
    @(negedge clk);
    lat = 1;
    snp_ack = v.ack;
    snp_shared = v.shr;
    snp_dirty = v.dty;
    mem_op = 0;
    maddr = '0;
    mwd = '0;
    n = 0;
    while (done == '0 && n < 40) begin
      @(negedge clk);
      lat++;
      n++;
      snp_ack = '0;
      snp_shared = '0;
      snp_dirty = '0;
      mem_ack = 1'b0;
      if (mem_req) begin
        mem_op = mem_we ? 2 : 1;
        maddr = mem_addr;
        mwd = mem_wdata;
        mem_rdata = v.rdata;
        mem_ack = 1'b1;
      end
    end
    mem_ack = 1'b0;
    chk("mem_op", mem_op, v.mem);
    if (v.mem != 0) chk("mem_addr", maddr, v.addr);
    if (v.mem == 2) chk("mem_wdata", mwd, v.edata);
    e = sb.pop_front();
    chk("done", done, e.done);
    chk("resp_shared", resp_shared, e.esh);
    chk("resp_data", resp_data, e.edata);
    chk("resp_err", resp_err, e.eerr);
    if (e.elat != 0) chk("latency", lat, e.elat);
    if (!hold) req[v.src] = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, '0);
    chk("resp_hold", resp_data, e.edata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < NUM_CPUS; i++) begin
      req_tx[i] = BUS_RD;
      snp_data[i] = {4{32'hDEADBEE0 | 32'(i)}};
    end
    //         src tx        addr        ack    shr    dty    rdata                mem esh   edata                 err   lat
    tbl[0] = '{2, BUS_RD,   32'h100, 4'hF, 4'h0, 4'h0, {16{8'hAB}},          1, 1'b0, {16{8'hAB}},          1'b0, 3};
    tbl[1] = '{0, BUS_RDX,  32'h240, 4'hF, 4'h0, 4'h8, {4{32'h12345678}},    2, 1'b1, {4{32'hDEADBEE3}},    1'b0, 3};
    tbl[2] = '{1, BUS_UPGR, 32'h080, 4'hF, 4'h4, 4'h0, {4{32'h11111111}},    0, 1'b1, '0,                   1'b0, 2};
    tbl[3] = '{0, BUS_RD,   32'h300, 4'hF, 4'h0, 4'hB, {4{32'h22222222}},    2, 1'b1, {4{32'hDEADBEE1}},    1'b1, 3};
    tbl[4] = '{1, BUS_UPGR, 32'h044, 4'hB, 4'h0, 4'h0, {4{32'h33333333}},    0, 1'b0, '0,                   1'b1, 16};
    tbl[5] = '{2, BUS_RD,   32'h500, 4'hF, 4'h4, 4'h0, {4{32'h5555AAAA}},    1, 1'b0, {4{32'h5555AAAA}},    1'b0, 3};
    rv[0]  = '{1, BUS_RD,   32'h900, 4'hF, 4'h0, 4'h0, {4{32'h0BADF00D}},    1, 1'b0, {4{32'h0BADF00D}},    1'b0, 3};
    rv[1]  = '{3, BUS_RDX,  32'hA00, 4'hF, 4'h1, 4'h0, {4{32'h600DCAFE}},    1, 1'b1, {4{32'h600DCAFE}},    1'b0, 3};

    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) do_tx(tbl[k], 1'b0);

    // abort a transaction stalled in MEM_RD; rr pointer was 3 before the reset
    req_addr[2] = 32'h700;
    req_tx[2] = BUS_RD;
    req[2] = 1'b1;
    n = 0;
    while (!mem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_mem_rd", mem_req, 1'b1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    req[3] = 1'b1;
    do_tx(rv[0], 1'b0);
    do_tx(rv[1], 1'b0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = '1;
    for (int i = 0; i < NUM_CPUS; i++) req_tx[i] = BUS_UPGR;
    for (int k = 0; k < 5; k++) begin
      fv = '{k % NUM_CPUS, BUS_UPGR, 32'h1000 + 32'(k) * 32'h40, 4'hF, 4'h0, 4'h0, '0, 0, 1'b0, '0, 1'b0, 2};
      do_tx(fv, 1'b1);
    end
    req = '0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
